sync_fifo_prog: RTL

//   Single-clock parametrised FIFO with programmable almost-full/almost-empty

---
 rtl/sync_fifo_prog_pkg.sv | 14 +
 rtl/sync_fifo_prog_ram.sv | 25 ++
 rtl/sync_fifo_prog.sv | 96 +++++++++
 3 files changed

// File: rtl/sync_fifo_prog_pkg.sv
// Shared sizing and parameter-checking helpers for the single-clock programmable FIFO.
// Both the top and the storage array derive their depth from here so the two cannot disagree.
package sync_fifo_prog_pkg;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Legal ranges: almost_full 1..DEPTH, almost_empty 0..DEPTH-1.
    function automatic bit thresh_ok(input int depth, input int af, input int ae);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_prog_ram.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the pointers alone define what is valid.
module sync_fifo_prog_ram
    import sync_fifo_prog_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, fill count,
// optional first-word-fall-through read and registered overflow/underflow pulses.
module sync_fifo_prog
    import sync_fifo_prog_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int PW    = ADDR_WIDTH + 1;

    if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_prog: AF_THRESH/AE_THRESH out of range");
    end

    logic [PW-1:0]         r_wptr, r_rptr, r_count;
    logic                  r_full, r_af, r_empty, r_ae, r_ov, r_un;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_wr_acc, w_rd_acc;
    logic [PW-1:0]         w_wptr_nxt, w_rptr_nxt, w_count_nxt;
    logic [DATA_WIDTH-1:0] w_ram_q;

    // Acceptance uses the registered flags, i.e. their value at the clock edge.
    assign w_wr_acc    = wr_en && !r_full;
    assign w_rd_acc    = rd_en && !r_empty;
    assign w_wptr_nxt  = r_wptr + PW'(w_wr_acc);
    assign w_rptr_nxt  = r_rptr + PW'(w_rd_acc);
    // Extra pointer bit makes the modulo-2*DEPTH difference an exact 0..DEPTH fill level.
    assign w_count_nxt = w_wptr_nxt - w_rptr_nxt;

    sync_fifo_prog_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
        .i_wdata (wr_data),
        .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_af      <= 1'b0;
            r_empty   <= 1'b1;
            r_ae      <= 1'b1;
            r_ov      <= 1'b0;
            r_un      <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == PW'(DEPTH));
            r_af    <= (w_count_nxt >= PW'(AF_THRESH));
            r_empty <= (w_count_nxt == '0);
            r_ae    <= (w_count_nxt <= PW'(AE_THRESH));
            r_ov    <= wr_en && r_full;
            r_un    <= rd_en && r_empty;
            // Popped word is kept so rd_data holds steady on idle or rejected reads.
            if (w_rd_acc) r_rd_data <= w_ram_q;
        end
    end

    assign rd_data      = (FWFT != 0 && !r_empty) ? w_ram_q : r_rd_data;
    assign full         = r_full;
    assign almost_full  = r_af;
    assign empty        = r_empty;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ov;
    assign underflow    = r_un;
endmodule
